// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StHeld,
        StRel
    } state_t;

    // one = exactly one key seen in the scan; code is its hex value.
    typedef struct packed {
        logic       one;
        logic [3:0] code;
    } class_t;

    localparam class_t CLASS_NONE = '{one: 1'b0, code: 4'h0};

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row, col}; row 0 is the top row, col 0 the leftmost column.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/keypad_col_driver.sv
// Column strobe rotation with per-column settle counter; flags sample and end-of-scan edges.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    output logic [1:0] col_idx,
    output logic       sample,
    output logic       scan_done
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [3:0]    col_q;
    logic [1:0]    idx_q;

    assign sample    = (cnt_q == LAST);
    assign scan_done = sample && (idx_q == 2'd3);
    assign col       = col_q;
    assign col_idx   = idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            col_q <= COL_RESET;
            idx_q <= 2'd0;
        end else if (sample) begin
            cnt_q <= '0;
            col_q <= {col_q[2:0], col_q[3]};
            idx_q <= idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sync, press matrix, ghost-rejecting classifier, debounce FSM, history.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int unsigned DW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DEB = DW'(DEBOUNCE_SCANS);

    logic [1:0]  col_idx;
    logic        sample;
    logic        scan_done;

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] matrix_q, matrix_d;
    logic [4:0]  ones;
    logic [3:0]  hit;
    class_t      class_d, class_q;
    logic        eval_q;

    state_t      state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic [15:0] digits_q, digits_d;
    logic        accept;
    logic [3:0]  accept_key;

    keypad_col_driver #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_col_driver (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .col_idx  (col_idx),
        .sample   (sample),
        .scan_done(scan_done)
    );

    always_comb begin
        matrix_d = matrix_q;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                matrix_d[{r[1:0], col_idx}] = ~row_sync_q[r];
            end
        end
    end

    // Classify the matrix including the column captured on this same edge.
    always_comb begin
        ones = '0;
        hit  = '0;
        for (int i = 0; i < 16; i++) begin
            if (matrix_d[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
        class_d.one  = (ones == 5'd1);
        class_d.code = (ones == 5'd1) ? KEY_MAP[hit] : 4'h0;
    end

    assign cnt_inc = cnt_q + DW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        held_d     = held_q;
        digits_d   = digits_q;
        accept     = 1'b0;
        accept_key = cand_q;
        if (eval_q) begin
            unique case (state_q)
                StIdle: begin
                    if (class_q.one) begin
                        cand_d = class_q.code;
                        cnt_d  = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            accept     = 1'b1;
                            accept_key = class_q.code;
                        end else begin
                            state_d = StPend;
                        end
                    end
                end
                StPend: begin
                    if (class_q.one && class_q.code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) accept = 1'b1;
                    end else if (class_q.one) begin
                        cand_d = class_q.code;
                        cnt_d  = DW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (!class_q.one) begin
                        cnt_d = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            held_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            state_d = StRel;
                        end
                    end
                end
                StRel: begin
                    if (!class_q.one) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            held_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (accept) begin
            code_d   = accept_key;
            valid_d  = 1'b1;
            held_d   = 1'b1;
            digits_d = {digits_q[11:0], accept_key};
            state_d  = StHeld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            matrix_q   <= '0;
            class_q    <= CLASS_NONE;
            eval_q     <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            cand_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            digits_q   <= '0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            matrix_q   <= matrix_d;
            if (scan_done) class_q <= class_d;
            eval_q     <= scan_done;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
            digits_q   <= digits_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign digits    = digits_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD layout) by rotating an active-low column strobe and sampling the active-low row inputs. Debounces over whole scans, rejects multi-key ghosting, and emits a one-cycle strobe per accepted keypress. Also shifts the accepted key into a 16-bit, four-nibble register that feeds the multiplexed seven-segment display path as its digit word. It is the input-side counterpart of the display scan: it drives the strobes and reads the lines back.

## Interface
- SETTLE_CYCLES, 1024: cycles each column is driven before rows are sampled; must be ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required for press or release; must be ≥ 1.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- row  input  4  keypad rows, active-low, asynchronous to clk.
- col  output 4  column strobe, active-low one-cold; the sequence is 1110 → 1101 → 1011 → 0111 → 1110.
- key_code  output 4  hex value of the last accepted key; it holds its value until the next accept.
- key_valid  output 1  one-cycle pulse on each accept.
- key_held  output 1  high from accept until the release is debounced.
- digits  output 16  accepted-key history. The newest key is in [3:0] and the oldest in [15:12].

## Operation
- Row synchronizer: two flops per row bit. Reset value is 1111.
- Column counter (width clog2(SETTLE_CYCLES)):
  - Increments every cycle.
  - At SETTLE_CYCLES-1, the synchronized row is captured into that column's 4 bits of a 16-bit press matrix (bit set = row low). In the same edge, col rotates and the counter clears.
- Key map (row r, col c), rows top to bottom:
  - 1 2 3 A
  - 4 5 6 B
  - 7 8 9 C
  - 0 F E D
- scan_done: the sample event taken while col = 0111.
  - At that edge, the full matrix is classified as NONE (0 bits set), ONE(code) (exactly 1 bit set) or MULTI (≥ 2 bits set).
  - MULTI is treated as NONE.
  - The classification is registered.
- FSM (evaluates only in the cycle after scan_done):
  - IDLE: ONE(k) sets cand = k, cnt = 1, and moves to PEND. If DEBOUNCE_SCANS = 1, it accepts directly.
  - PEND:
    - ONE(cand) increments cnt. When cnt reaches DEBOUNCE_SCANS, the key is accepted.
    - ONE(other k) reloads cand = k and cnt = 1.
    - NONE returns to IDLE.
  - Accept does all of the following: key_code ← cand, key_valid pulse, key_held ← 1, digits ← {digits[11:0], cand}, then go to HELD.
  - HELD: NONE sets cnt = 1 and moves to REL. Any ONE stays in HELD. A different key without an intermediate release is never a new press.
  - REL:
    - NONE increments cnt. At DEBOUNCE_SCANS, key_held ← 0 and the FSM goes to IDLE.
    - ONE(any) returns to HELD.
- Boundaries:
  - Counter wrap and column rotation never skip or repeat a column.
  - A key held indefinitely produces exactly one key_valid.
  - digits discards the oldest nibble on every accept.
- Reset is synchronous and may occur mid-scan, mid-debounce or mid-hold. It takes effect at the next edge with rst high.
- Reset values:
  - col = 1110, counter 0, matrix 0, classification NONE
  - state IDLE, cnt 0, cand 0
  - key_code 0, key_valid 0, key_held 0, digits 0
  - synchronizers 1111
- A key pressed through reset is treated as a fresh press after reset is released.

## Timing
- One full scan takes 4·SETTLE_CYCLES cycles. The first scan_done falls at cycle 4·SETTLE_CYCLES-1 after reset is released.
- Row-to-matrix latency: 2 synchronizer cycles. A row must be stable for the 2 cycles before the sample edge to be captured.
- If scan_done is at cycle N, the FSM updates at the end of cycle N+1. key_valid is high only in cycle N+2, and key_code, digits and key_held are updated in that same cycle.
- Press latency from a clean, stable press: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scans, plus 3 cycles.
- Outputs are registered. There is no handshake: a consumer must sample key_valid every cycle.

## Structure
- Shared package keypad_pkg holds:
  - the 16-entry key map as a constant, indexed by {row, col}
  - the FSM state enum (IDLE, PEND, HELD, REL)
  - the classification encoding
  - column reset constant 4'b1110
- One sub-module, keypad_col_driver: column counter, strobe rotation, sample and scan_done pulses. The main module holds the synchronizer, matrix, classifier, FSM and digits register.

## Test plan
All scenarios run with SETTLE_CYCLES = 4 and DEBOUNCE_SCANS = 2 (16-cycle scan).
- Reset and idle: col cycles 1110/1101/1011/0111 every 4 cycles. All outputs stay 0 for 200 cycles with row = 1111.
- Single press: hold row[1] low only while col = 1011 (key 6) for 5 scans, then release.
  - Exactly one key_valid, key_code = 6, digits = 0x0006.
  - key_held falls 2 scans (+3 cycles) after release.
- Bounce: toggle key 5 on alternate scans. No key_valid occurs.
- Ghosting: hold keys 1 and 2 together for 6 scans. No key_valid occurs. Then release 2 and keep 1 held: one key_valid with key_code = 1.
- History: press and release 1, A, 0, D, then 7 in sequence.
  - digits reads 0x001A, then 0x01A0, then 0x1A0D, then 0xA0D7.
  - key_valid count is 5.
- Reset mid-hold: assert rst for 1 cycle while key 9 is in HELD.
  - All outputs return to reset values at the next edge.
  - With 9 still held, one new key_valid with key_code = 9 arrives after 2 scans.
